// File: rtl/inst_mem_loader_if.sv
// Byte-stream and instruction-memory write bus for inst_mem_loader.
// master: the loader (consumes bytes, drives memory writes).
// slave:  the environment (byte source plus instruction memory).
interface inst_mem_loader_if #(
  parameter int ADDR_WIDTH = 7
);
  logic                  s_valid;
  logic [7:0]            s_data;
  logic                  s_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    input  s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Program loader: assembles little-endian 32-bit words from a byte stream,
// writes them to instruction memory at incrementing word addresses and holds
// the CPU in reset (cpu_rstn=0) until the image is written.
// Optional macro INST_MEM_LOADER_PAD_EN: fill the rest of memory with NOPs
// and a terminating self-loop JAL before releasing the CPU.
module inst_mem_loader #(
  parameter int ADDR_WIDTH    = 7,
  parameter int RELEASE_DELAY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   n_words,
  inst_mem_loader_if.master     bus,
  output logic                  cpu_rstn,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam int DW = (RELEASE_DELAY > 0) ? $clog2(RELEASE_DELAY + 1) : 1;
  localparam logic [DW-1:0] DLY_LAST = DW'(RELEASE_DELAY);
`ifdef INST_MEM_LOADER_PAD_EN
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [31:0] JAL_WORD = 32'h0000_006F;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
`ifdef INST_MEM_LOADER_PAD_EN
    PAD,
`endif
    RELEASE,
    DONE
  } state_t;

  state_t              state;
  logic [ADDR_WIDTH:0] n_words_q;
  logic [ADDR_WIDTH:0] word_cnt;
  logic [1:0]          byte_cnt;
  logic [23:0]         word_buf;
  logic [DW-1:0]       dly_cnt;
  logic                start_ok;
  logic                xfer;

  assign bus.s_ready = (state == LOAD);
  assign xfer        = bus.s_valid && (state == LOAD);
  assign start_ok    = (n_words != '0) && (n_words <= DEPTH_W);

  // Loader FSM with registered memory-bus and status outputs.
  // The final image write is already on the bus in the first RELEASE/PAD
  // cycle, so RELEASE counts RELEASE_DELAY+1 cycles including that one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      n_words_q     <= '0;
      word_cnt      <= '0;
      byte_cnt      <= '0;
      word_buf      <= '0;
      dly_cnt       <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_rstn      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (start_ok) begin
              state     <= LOAD;
              n_words_q <= n_words;
              word_cnt  <= '0;
              byte_cnt  <= '0;
              word_buf  <= '0;
              dly_cnt   <= '0;
              err       <= 1'b0;
              cpu_rstn  <= 1'b0;
              busy      <= 1'b1;
              done      <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 1'b1;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= bus.s_data;
              2'd1: word_buf[15:8]  <= bus.s_data;
              2'd2: word_buf[23:16] <= bus.s_data;
              default: begin
                bus.mem_we    <= 1'b1;
                bus.mem_addr  <= word_cnt[ADDR_WIDTH-1:0];
                bus.mem_wdata <= {bus.s_data, word_buf};
                word_cnt      <= word_cnt + 1'b1;
                if (word_cnt == n_words_q - 1'b1) begin
`ifdef INST_MEM_LOADER_PAD_EN
                  state <= (n_words_q == DEPTH_W) ? RELEASE : PAD;
`else
                  state <= RELEASE;
`endif
                end
              end
            endcase
          end
        end
`ifdef INST_MEM_LOADER_PAD_EN
        PAD: begin
          bus.mem_we   <= 1'b1;
          bus.mem_addr <= word_cnt[ADDR_WIDTH-1:0];
          word_cnt     <= word_cnt + 1'b1;
          if (word_cnt[ADDR_WIDTH-1:0] == '1) begin
            bus.mem_wdata <= JAL_WORD;
            state         <= RELEASE;
          end else begin
            bus.mem_wdata <= NOP_WORD;
          end
        end
`endif
        RELEASE: begin
          if (dly_cnt == DLY_LAST) begin
            state    <= DONE;
            cpu_rstn <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader (ADDR_WIDTH=7,
// RELEASE_DELAY=4). A negedge monitor models the instruction memory.
module tb_inst_mem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] n_words;
  logic       cpu_rstn;
  logic       busy;
  logic       done;
  logic       err;

  inst_mem_loader_if #(.ADDR_WIDTH(7)) bus ();

  inst_mem_loader #(.ADDR_WIDTH(7), .RELEASE_DELAY(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n_words  (n_words),
    .bus      (bus),
    .cpu_rstn (cpu_rstn),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Memory model and event monitor.
  logic [31:0] mem [0:127];
  int          cyc = 0;
  int          wr_cnt = 0;
  int          last_we = 0;
  int          rise = 0;
  logic [6:0]  last_addr = '0;
  logic        we_d = 1'b0;
  logic        rstn_d = 1'b0;
  logic        b2b = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_cnt    <= wr_cnt + 1;
      last_we   <= cyc;
      last_addr <= bus.mem_addr;
    end
    if (bus.mem_we && we_d) b2b <= 1'b1;
    we_d <= bus.mem_we;
    if (cpu_rstn && !rstn_d) rise <= cyc;
    rstn_d <= cpu_rstn;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    for (int i = 0; i < 50; i++) begin
      if (bus.s_ready) begin
        @(negedge clk);
        bus.s_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("s_ready_timeout", 32'(bus.s_ready), 32'd1);
    bus.s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int unsigned k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic pulse_start(input logic [7:0] n);
    start   = 1'b1;
    n_words = n;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) return;
      @(negedge clk);
    end
    chk("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base;

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    n_words     = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_s_ready",   32'(bus.s_ready), 32'd0);
    chk("rst_mem_we",    32'(bus.mem_we),  32'd0);
    chk("rst_mem_addr",  32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata,    32'd0);
    chk("rst_cpu_rstn",  32'(cpu_rstn),    32'd0);
    chk("rst_busy",      32'(busy),        32'd0);
    chk("rst_done",      32'(done),        32'd0);
    chk("rst_err",       32'(err),         32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single word, back-to-back bytes
    base = wr_cnt;
    pulse_start(8'd1);
    chk("t1_busy",    32'(busy),        32'd1);
    chk("t1_s_ready", 32'(bus.s_ready), 32'd1);
    chk("t1_rstn",    32'(cpu_rstn),    32'd0);
    send_word(32'h0000_0013);
    wait_done(50);
    @(negedge clk);
    chk("t1_writes",  32'(wr_cnt - base), 32'd1);
    chk("t1_addr",    32'(last_addr),     32'd0);
    chk("t1_data",    mem[0],             32'h0000_0013);
    chk("t1_release", 32'(rise - last_we), 32'd5);
    chk("t1_done",    32'(done),          32'd1);
    chk("t1_rstn_hi", 32'(cpu_rstn),      32'd1);
    chk("t1_busy_lo", 32'(busy),          32'd0);

    // Restart from DONE, two words with gaps, start ignored mid-load
    base = wr_cnt;
    pulse_start(8'd2);
    chk("t2_rstn_drop", 32'(cpu_rstn), 32'd0);
    chk("t2_done_lo",   32'(done),     32'd0);
    send_byte(8'hEF); @(negedge clk);
    send_byte(8'hBE); @(negedge clk);
    send_byte(8'hAD); @(negedge clk);
    pulse_start(8'd0);
    chk("t2_ign_err",  32'(err),  32'd0);
    chk("t2_ign_busy", 32'(busy), 32'd1);
    send_byte(8'hDE); @(negedge clk);
    send_byte(8'h78); @(negedge clk);
    send_byte(8'h56); @(negedge clk);
    send_byte(8'h34); @(negedge clk);
    send_byte(8'h12);
    wait_done(60);
    @(negedge clk);
    chk("t2_writes", 32'(wr_cnt - base), 32'd2);
    chk("t2_w0",     mem[0], 32'hDEAD_BEEF);
    chk("t2_w1",     mem[1], 32'h1234_5678);
    chk("t2_rstn",   32'(cpu_rstn), 32'd1);

    // Invalid starts from IDLE
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = wr_cnt;
    pulse_start(8'd0);
    chk("t3_err0",     32'(err),         32'd1);
    chk("t3_busy0",    32'(busy),        32'd0);
    chk("t3_s_ready0", 32'(bus.s_ready), 32'd0);
    pulse_start(8'd129);
    @(negedge clk);
    chk("t3_err129",   32'(err),         32'd1);
    chk("t3_busy129",  32'(busy),        32'd0);
    chk("t3_rstn",     32'(cpu_rstn),    32'd0);
    chk("t3_nowrite",  32'(wr_cnt - base), 32'd0);

    // Valid start clears err; reset mid-word
    pulse_start(8'd3);
    chk("t4_err_clr", 32'(err),  32'd0);
    chk("t4_busy",    32'(busy), 32'd1);
    send_word(32'hDDCC_BBAA);
    send_byte(8'h11);
    send_byte(8'h22);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_busy",   32'(busy),         32'd0);
    chk("t4_rst_ready",  32'(bus.s_ready),  32'd0);
    chk("t4_rst_we",     32'(bus.mem_we),   32'd0);
    chk("t4_rst_addr",   32'(bus.mem_addr), 32'd0);
    chk("t4_rst_wdata",  bus.mem_wdata,     32'd0);
    chk("t4_rst_rstn",   32'(cpu_rstn),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = wr_cnt;
    pulse_start(8'd1);
    send_word(32'h1122_3344);
    wait_done(50);
    @(negedge clk);
    chk("t4_writes", 32'(wr_cnt - base), 32'd1);
    chk("t4_addr",   32'(last_addr),     32'd0);
    chk("t4_data",   mem[0],             32'h1122_3344);

    // Full-depth image: no wrap, no padding
    base = wr_cnt;
    pulse_start(8'd128);
    for (int unsigned i = 0; i < 128; i++) send_word({24'h302010, 8'(i)});
    wait_done(100);
    @(negedge clk);
    chk("t5_writes", 32'(wr_cnt - base), 32'd128);
    chk("t5_last",   32'(last_addr),     32'd127);
    chk("t5_w0",     mem[0],             32'h3020_1000);
    chk("t5_w64",    mem[64],            32'h3020_1040);
    chk("t5_w127",   mem[127],           32'h3020_107F);
    chk("t5_rstn",   32'(cpu_rstn),      32'd1);

    // Short image: padding or untouched tail
    base = wr_cnt;
    pulse_start(8'd3);
    send_word(32'h0403_0201);
    send_word(32'h0807_0605);
    send_word(32'h0C0B_0A09);
    wait_done(300);
    @(negedge clk);
    chk("t6_w2",      mem[2],             32'h0C0B_0A09);
    chk("t6_release", 32'(rise - last_we), 32'd5);
`ifdef INST_MEM_LOADER_PAD_EN
    chk("t6_writes",  32'(wr_cnt - base), 32'd128);
    chk("t6_last",    32'(last_addr),     32'd127);
    chk("t6_w3",      mem[3],             32'h0000_0013);
    chk("t6_w126",    mem[126],           32'h0000_0013);
    chk("t6_w127",    mem[127],           32'h0000_006F);
`else
    chk("t6_writes",  32'(wr_cnt - base), 32'd3);
    chk("t6_last",    32'(last_addr),     32'd2);
    chk("t6_w3",      mem[3],             32'h3020_1003);
    chk("t6_w127",    mem[127],           32'h3020_107F);
    chk("b2b_we",     32'(b2b),           32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
